ex_muldiv_unit: RTL and testbench

Execute-stage RV32M multiply/divide unit. Consumes the operand and funct3 fields held in the ID/EX pipeline register and returns a 32-bit result to the EX-stage writeback mux. Multiplies complete in one cycle. Divides and remainders use a 32-iteration restoring divider. OUT_BUSY feeds the pipeline BUSYWAIT/stall network so that ID/EX and the upstream registers hold while the unit works.

---
 rtl/ex_muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// RV32M execute-stage multiply/divide unit: single-cycle multiply, 32-iteration
// restoring divider, and single-cycle divide-by-zero / signed-overflow results.
module ex_muldiv_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IN_START,
  input  logic [2:0]  IN_OP,
  input  logic [31:0] IN_DATA1,
  input  logic [31:0] IN_DATA2,
  input  logic        IN_FLUSH,
  output logic [31:0] OUT_RESULT,
  output logic        OUT_BUSY,
  output logic        OUT_DONE,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is taken on any edge where IN_START=1, IN_FLUSH=0 and
  // the unit is in IDLE or DONE; OUT_DONE then pulses once with OUT_RESULT.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] rem_q;
  logic [4:0]  cnt_q;
  logic        fix_q;
  logic        sign1_q;
  logic        sign2_q;

  logic        accept;
  logic        in_signed;
  logic        in_special;
  logic        neg1;
  logic        neg2;
  logic [31:0] mag1;
  logic [31:0] mag2;

  always_comb begin
    accept     = ((state_q == S_IDLE) || (state_q == S_DONE)) && IN_START && !IN_FLUSH;
    in_signed  = ~IN_OP[0];
    in_special = IN_OP[2] && ((IN_DATA2 == 32'd0) ||
                 (in_signed && (IN_DATA1 == 32'h8000_0000) && (IN_DATA2 == 32'hFFFF_FFFF)));
    // Special cases keep raw operands; only real divides are converted to magnitudes.
    neg1 = IN_OP[2] && !in_special && in_signed && IN_DATA1[31];
    neg2 = IN_OP[2] && !in_special && in_signed && IN_DATA2[31];
    mag1 = neg1 ? (32'd0 - IN_DATA1) : IN_DATA1;
    mag2 = neg2 ? (32'd0 - IN_DATA2) : IN_DATA2;
  end

  logic        a_sx;
  logic        b_sx;
  logic [63:0] prod;
  logic [31:0] mul_res;

  always_comb begin
    a_sx = ((op_q[1:0] == 2'b01) || (op_q[1:0] == 2'b10)) && a_q[31];
    b_sx = (op_q[1:0] == 2'b01) && b_q[31];
    prod = {{32{a_sx}}, a_q} * {{32{b_sx}}, b_q};
    if (op_q[2]) begin
      if (b_q == 32'd0) mul_res = op_q[1] ? a_q : 32'hFFFF_FFFF;
      else              mul_res = op_q[1] ? 32'd0 : 32'h8000_0000;
    end else if (op_q[1:0] == 2'b00) begin
      mul_res = prod[31:0];
    end else begin
      mul_res = prod[63:32];
    end
  end

  // a_q doubles as the dividend shifter and the quotient accumulator.
  logic [32:0] r_shift;
  logic [32:0] diff;
  logic        q_bit;
  logic [31:0] rem_next;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [31:0] div_res;

  always_comb begin
    r_shift  = {rem_q, a_q[31]};
    diff     = r_shift - {1'b0, b_q};
    q_bit    = ~diff[32];
    rem_next = q_bit ? diff[31:0] : r_shift[31:0];
    q_fix    = (sign1_q ^ sign2_q) ? (32'd0 - a_q) : a_q;
    r_fix    = sign1_q ? (32'd0 - rem_q) : rem_q;
    div_res  = op_q[1] ? r_fix : q_fix;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      op_q       <= 3'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      rem_q      <= 32'd0;
      cnt_q      <= 5'd0;
      fix_q      <= 1'b0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      OUT_RESULT <= 32'd0;
      OUT_BUSY   <= 1'b0;
      OUT_DONE   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          OUT_DONE <= 1'b0;
          if (accept) begin
            op_q     <= IN_OP;
            a_q      <= mag1;
            b_q      <= mag2;
            sign1_q  <= neg1;
            sign2_q  <= neg2;
            rem_q    <= 32'd0;
            cnt_q    <= 5'd0;
            fix_q    <= 1'b0;
            OUT_BUSY <= 1'b1;
            state_q  <= (IN_OP[2] && !in_special) ? S_DIV : S_MUL;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_MUL: begin
          OUT_BUSY <= 1'b0;
          if (IN_FLUSH) begin
            state_q <= S_IDLE;
          end else begin
            OUT_RESULT <= mul_res;
            OUT_DONE   <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_DIV: begin
          if (IN_FLUSH) begin
            OUT_BUSY <= 1'b0;
            state_q  <= S_IDLE;
          end else if (!fix_q) begin
            a_q   <= {a_q[30:0], q_bit};
            rem_q <= rem_next;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) fix_q <= 1'b1;
          end else begin
            OUT_RESULT <= div_res;
            OUT_DONE   <= 1'b1;
            OUT_BUSY   <= 1'b0;
            state_q    <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: expected results are queued at issue and
// checked against OUT_RESULT when OUT_DONE pulses.
module tb_ex_muldiv_unit;

  logic        CLK;
  logic        RESET;
  logic        IN_START;
  logic [2:0]  IN_OP;
  logic [31:0] IN_DATA1;
  logic [31:0] IN_DATA2;
  logic        IN_FLUSH;
  logic [31:0] OUT_RESULT;
  logic        OUT_BUSY;
  logic        OUT_DONE;
  logic [1:0]  dbg_state;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = 32'd0;

  ex_muldiv_unit dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IN_START  (IN_START),
    .IN_OP     (IN_OP),
    .IN_DATA1  (IN_DATA1),
    .IN_DATA2  (IN_DATA2),
    .IN_FLUSH  (IN_FLUSH),
    .OUT_RESULT(OUT_RESULT),
    .OUT_BUSY  (OUT_BUSY),
    .OUT_DONE  (OUT_DONE),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  // drive one request for a single edge, then scramble inputs
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic start, input logic flush);
    @(negedge CLK);
    IN_START = start;
    IN_FLUSH = flush;
    IN_OP    = op;
    IN_DATA1 = a;
    IN_DATA2 = b;
    @(posedge CLK);
    #1;
    IN_START = 1'b0;
    IN_FLUSH = 1'b0;
    IN_OP    = 3'($urandom_range(0, 7));
    IN_DATA1 = $urandom;
    IN_DATA2 = $urandom;
  endtask

  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expv);
    exp_q.push_back(expv);
    drive(op, a, b, 1'b1, 1'b0);
    check({tag, "_busy_at_accept"}, 32'(OUT_BUSY), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int lat);
    int          cyc;
    logic        seen;
    logic [31:0] e;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (OUT_DONE) seen = 1'b1;
      else check({tag, "_busy"}, 32'(OUT_BUSY), 32'd1);
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
    check({tag, "_busy_at_done"}, 32'(OUT_BUSY), 32'd0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_result"}, OUT_RESULT, e);
      last_res = e;
    end else begin
      check({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd1);
    end
  endtask

  logic [2:0]  mops [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
  logic [31:0] mexp [4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'h0000_0006, 32'h0000_0006};
  logic [2:0]  dops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
  logic [31:0] dexp [4] = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'h5555_554E, 32'h0000_0002};
  logic [2:0]  sops [5] = '{3'd4, 3'd6, 3'd5, 3'd4, 3'd6};
  logic [31:0] sa   [5] = '{32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] sb   [5] = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] sexp [5] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};

  initial begin
    logic any_done;
    RESET    = 1'b1;
    IN_START = 1'b0;
    IN_FLUSH = 1'b0;
    IN_OP    = 3'd0;
    IN_DATA1 = 32'd0;
    IN_DATA2 = 32'd0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_result", OUT_RESULT, 32'd0);
    check("reset_busy", 32'(OUT_BUSY), 32'd0);
    check("reset_done", 32'(OUT_DONE), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 4; i++) begin
      issue($sformatf("mul%0d", i), mops[i], 32'h0000_0007, 32'hFFFF_FFFD, mexp[i]);
      wait_done($sformatf("mul%0d", i), 1);
    end

    for (int i = 0; i < 5; i++) begin
      issue($sformatf("spec%0d", i), sops[i], sa[i], sb[i], sexp[i]);
      wait_done($sformatf("spec%0d", i), 1);
    end

    for (int i = 0; i < 4; i++) begin
      issue($sformatf("div%0d", i), dops[i], 32'hFFFF_FFEC, 32'd3, dexp[i]);
      wait_done($sformatf("div%0d", i), 33);
    end

    // asynchronous reset in the middle of a divide
    drive(3'd4, 32'd100, 32'd7, 1'b1, 1'b0);
    repeat (10) @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    check("midreset_result", OUT_RESULT, 32'd0);
    check("midreset_busy", 32'(OUT_BUSY), 32'd0);
    check("midreset_done", 32'(OUT_DONE), 32'd0);
    check("midreset_state", 32'(dbg_state), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    last_res = 32'd0;
    issue("post_reset_div", 3'd4, 32'd100, 32'd7, 32'd14);
    wait_done("post_reset_div", 33);

    // START while dividing is ignored
    issue("busy_div", 3'd5, 32'd1000, 32'd7, 32'd142);
    repeat (3) @(posedge CLK);
    drive(3'd3, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 1'b0);
    check("busy_ignore_busy", 32'(OUT_BUSY), 32'd1);
    check("busy_ignore_state", 32'(dbg_state), 32'd2);
    wait_done("busy_div", 29);

    // flush at the fifth iteration
    drive(3'd5, 32'd1000, 32'd3, 1'b1, 1'b0);
    repeat (4) @(posedge CLK);
    drive(3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    check("flush_busy", 32'(OUT_BUSY), 32'd0);
    check("flush_done", 32'(OUT_DONE), 32'd0);
    check("flush_result", OUT_RESULT, last_res);
    check("flush_state", 32'(dbg_state), 32'd0);
    any_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      #1;
      any_done = any_done | OUT_DONE;
    end
    check("flush_no_done", 32'(any_done), 32'd0);

    // START together with FLUSH in IDLE is dropped
    drive(3'd0, 32'd7, 32'd3, 1'b1, 1'b1);
    check("startflush_busy", 32'(OUT_BUSY), 32'd0);
    check("startflush_state", 32'(dbg_state), 32'd0);
    @(posedge CLK);
    #1;
    check("startflush_done", 32'(OUT_DONE), 32'd0);
    check("startflush_result", OUT_RESULT, last_res);

    // back-to-back: DIVU issued during the DONE cycle of a MUL
    issue("b2b_mul", 3'd0, 32'd6, 32'd7, 32'd42);
    wait_done("b2b_mul", 1);
    check("b2b_in_done_state", 32'(dbg_state), 32'd3);
    issue("b2b_divu", 3'd5, 32'd9, 32'd2, 32'd4);
    check("b2b_no_idle_gap", 32'(dbg_state), 32'd2);
    wait_done("b2b_divu", 33);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
